// File: rtl/lsu_rv32.sv
// ============================================================================
// Module   : lsu_rv32
// Purpose  : RV32I load/store unit for the MEM stage. Converts loads and
//            stores into word-wide data-cache transactions; sub-word stores
//            are performed as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_rv32 #(
  parameter int MEMSIZE = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iREQ,
  input  logic        iLOAD,
  input  logic [2:0]  iFUNCT3,
  input  logic [31:0] iADDR,
  input  logic [31:0] iWDATA,
  output logic        oBUSY,
  output logic        oDONE,
  output logic [31:0] oRDATA,
  output logic        oEXC,
  output logic [1:0]  oCAUSE,
  output logic        oMEM,
  output logic        oRW,
  output logic [31:0] oMEMADDR,
  output logic [31:0] oMEMDATA,
  input  logic [31:0] iMEMDATA,
  input  logic        iStallD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam logic [29:0] MEM_WORDS = 30'(MEMSIZE);

  state_t      state;
  logic        is_load;
  logic [2:0]  funct3;
  logic [31:0] addr;
  // Holds the store data from accept; for sub-word stores it is replaced by
  // the merged word in CAP, so WR always drives this register.
  logic [31:0] wr_word;

  logic        req_illegal;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic [1:0]  req_cause;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] store_merge;

  // Request fault classification; priority illegal > misaligned > range.
  always_comb begin
    req_illegal      = (iFUNCT3 == 3'b011) || (iFUNCT3 == 3'b110) ||
                       (iFUNCT3 == 3'b111) || (!iLOAD && iFUNCT3[2]);
    req_misaligned   = ((iFUNCT3[1:0] == 2'b01) && iADDR[0]) ||
                       ((iFUNCT3[1:0] == 2'b10) && (iADDR[1:0] != 2'b00));
    req_out_of_range = (iADDR[31:2] >= MEM_WORDS);
    if (req_illegal)           req_cause = 2'b11;
    else if (req_misaligned)   req_cause = 2'b01;
    else if (req_out_of_range) req_cause = 2'b10;
    else                       req_cause = 2'b00;
  end

  // Lane extraction and extension of the word returned by the cache.
  always_comb begin
    case (addr[1:0])
      2'd0:    rd_byte = iMEMDATA[7:0];
      2'd1:    rd_byte = iMEMDATA[15:8];
      2'd2:    rd_byte = iMEMDATA[23:16];
      default: rd_byte = iMEMDATA[31:24];
    endcase
    rd_half = addr[1] ? iMEMDATA[31:16] : iMEMDATA[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = iMEMDATA;
    endcase
  end

  // Merge the store byte/half into the word read back from the cache.
  always_comb begin
    store_merge = iMEMDATA;
    if (funct3[1:0] == 2'b00) begin
      case (addr[1:0])
        2'd0:    store_merge[7:0]   = wr_word[7:0];
        2'd1:    store_merge[15:8]  = wr_word[7:0];
        2'd2:    store_merge[23:16] = wr_word[7:0];
        default: store_merge[31:24] = wr_word[7:0];
      endcase
    end else if (funct3[1:0] == 2'b01) begin
      if (addr[1]) store_merge[31:16] = wr_word[15:0];
      else         store_merge[15:0]  = wr_word[15:0];
    end else begin
      store_merge = wr_word;
    end
  end

  // Cache port decoded from the state register so reset drops it at once.
  always_comb begin
    oBUSY    = (state != IDLE);
    oMEM     = (state == RD) || (state == WR);
    oRW      = (state == RD);
    oMEMADDR = oMEM ? {2'b00, addr[31:2]} : 32'd0;
    oMEMDATA = (state == WR) ? wr_word : 32'd0;
  end

  // Main FSM with registered completion/exception pulses and results.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= IDLE;
      is_load <= 1'b0;
      funct3  <= 3'd0;
      addr    <= 32'd0;
      wr_word <= 32'd0;
      oDONE   <= 1'b0;
      oRDATA  <= 32'd0;
      oEXC    <= 1'b0;
      oCAUSE  <= 2'b00;
    end else begin
      oDONE <= 1'b0;
      oEXC  <= 1'b0;
      case (state)
        IDLE: begin
          if (iREQ) begin
            is_load <= iLOAD;
            funct3  <= iFUNCT3;
            addr    <= iADDR;
            wr_word <= iWDATA;
            if (req_cause != 2'b00) begin
              oEXC   <= 1'b1;
              oCAUSE <= req_cause;
            end else if (!iLOAD && (iFUNCT3[1:0] == 2'b10)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (!iStallD) state <= CAP;
        end
        CAP: begin
          if (is_load) begin
            oRDATA <= load_ext;
            oDONE  <= 1'b1;
            state  <= IDLE;
          end else begin
            wr_word <= store_merge;
            state   <= WR;
          end
        end
        WR: begin
          if (!iStallD) begin
            oDONE <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_rv32.sv
// ============================================================================
// Module   : tb_lsu_rv32
// Purpose  : Directed self-checking bench for lsu_rv32 with a small
//            behavioural data cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_rv32;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iREQ = 1'b0;
  logic        iLOAD = 1'b0;
  logic [2:0]  iFUNCT3 = 3'd0;
  logic [31:0] iADDR = 32'd0;
  logic [31:0] iWDATA = 32'd0;
  logic        oBUSY, oDONE, oEXC, oMEM, oRW;
  logic [31:0] oRDATA, oMEMADDR, oMEMDATA;
  logic [1:0]  oCAUSE;
  logic [31:0] iMEMDATA = 32'd0;
  logic        iStallD = 1'b0;

  int checks = 0;
  int errors = 0;

  // cache model and preload port
  logic [31:0] mem [0:7];
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [31:0] pl_val = 32'd0;

  // per-access observations
  int          lat;
  logic        exc_seen;
  int          mem_seen;
  logic        first_seen;
  logic [31:0] first_addr;
  logic        first_rw;
  logic        have_wr;
  logic [31:0] last_wr;
  logic        wr_unstable;

  lsu_rv32 #(.MEMSIZE(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iLOAD(iLOAD), .iFUNCT3(iFUNCT3),
    .iADDR(iADDR), .iWDATA(iWDATA), .oBUSY(oBUSY), .oDONE(oDONE),
    .oRDATA(oRDATA), .oEXC(oEXC), .oCAUSE(oCAUSE), .oMEM(oMEM), .oRW(oRW),
    .oMEMADDR(oMEMADDR), .oMEMDATA(oMEMDATA), .iMEMDATA(iMEMDATA),
    .iStallD(iStallD)
  );

  always #5 iCLK = ~iCLK;

  // cache: read data appears the cycle after the read is sampled
  always @(posedge iCLK) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (oMEM && !iStallD) begin
      if (oRW) iMEMDATA <= mem[oMEMADDR[2:0]];
      else     mem[oMEMADDR[2:0]] <= oMEMDATA;
    end
  end

  task automatic preload(input logic [2:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge iCLK); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, scramble inputs afterwards, and wait for oDONE/oEXC.
  // lat counts cycles from the request edge (request cycle = 1).
  task automatic run_access(input logic ld, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int nstall);
    logic fin;
    int   n;
    n = nstall;
    iLOAD = ld; iFUNCT3 = f3; iADDR = a; iWDATA = wd; iStallD = 1'b0;
    iREQ = 1'b1;
    lat = -1; exc_seen = 1'b0; mem_seen = 0; first_seen = 1'b0;
    first_addr = 32'd0; first_rw = 1'b0; have_wr = 1'b0; last_wr = 32'd0;
    wr_unstable = 1'b0; fin = 1'b0;
    @(posedge iCLK); #1;
    iREQ = 1'b0; iLOAD = ~ld; iFUNCT3 = 3'b111; iADDR = 32'hFFFF_FFFF;
    iWDATA = 32'hA5A5_A5A5;
    for (int k = 1; k <= 20; k++) begin
      if (!fin) begin
        if (oDONE || oEXC) begin
          lat = k; exc_seen = oEXC; fin = 1'b1;
        end else begin
          if (oMEM) begin
            mem_seen++;
            if (!first_seen) begin
              first_seen = 1'b1; first_addr = oMEMADDR; first_rw = oRW;
            end
            if (!oRW) begin
              if (have_wr && (oMEMDATA !== last_wr)) wr_unstable = 1'b1;
              last_wr = oMEMDATA; have_wr = 1'b1;
            end
          end
          iStallD = (n > 0);
          if (n > 0) n--;
          @(posedge iCLK); #1;
        end
      end
    end
    iStallD = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({oBUSY, oDONE, oRDATA, oEXC, oCAUSE, oMEM, oRW, oMEMADDR, oMEMDATA} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    @(posedge iCLK); #1;
    iRST = 1'b0;
    @(posedge iCLK); #1;
    iLOAD = 1'b1; iFUNCT3 = 3'b010; iADDR = 32'h8; iStallD = 1'b1; iREQ = 1'b1;
    @(posedge iCLK); #1;
    iREQ = 1'b0;
    checks++;
    if (oMEM !== 1'b1) begin
      errors++; $display("FAIL reset_pre_rd: oMEM=%b required 1", oMEM);
    end
    iRST = 1'b1; #1;
    checks++;
    if ({oMEM, oBUSY} !== 2'b00) begin
      errors++; $display("FAIL reset_async: oMEM/oBUSY=%b required 00", {oMEM, oBUSY});
    end
    @(posedge iCLK); #1;
    iRST = 1'b0; iStallD = 1'b0;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    checks++;
    if ({oBUSY, oDONE, oRDATA, oEXC, oCAUSE, oMEM, oRW, oMEMADDR, oMEMDATA} !== '0) begin
      errors++; $display("FAIL reset_release: got nonzero outputs, required all 0");
    end
  endtask

  task automatic test_lw;
    preload(3'd2, 32'hDEADBEEF);
    run_access(1'b1, 3'b010, 32'h8, 32'd0, 0);
    checks++;
    if ({first_addr, first_rw} !== {32'd2, 1'b1}) begin
      errors++; $display("FAIL lw_port: addr=%h rw=%b required 2/1", first_addr, first_rw);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d required 3", lat); end
    checks++;
    if (oRDATA !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got %h required deadbeef", oRDATA);
    end
  endtask

  task automatic test_sub_loads;
    preload(3'd2, 32'h80FF7F01);
    run_access(1'b1, 3'b000, 32'hB, 32'd0, 0);
    checks++;
    if (oRDATA !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb: got %h required ffffff80", oRDATA);
    end
    run_access(1'b1, 3'b100, 32'hB, 32'd0, 0);
    checks++;
    if (oRDATA !== 32'h00000080) begin
      errors++; $display("FAIL lbu: got %h required 00000080", oRDATA);
    end
    preload(3'd1, 32'h8001ABCD);
    run_access(1'b1, 3'b001, 32'h6, 32'd0, 0);
    checks++;
    if (oRDATA !== 32'hFFFF8001) begin
      errors++; $display("FAIL lh: got %h required ffff8001", oRDATA);
    end
    run_access(1'b1, 3'b101, 32'h4, 32'd0, 0);
    checks++;
    if (oRDATA !== 32'h0000ABCD) begin
      errors++; $display("FAIL lhu: got %h required 0000abcd", oRDATA);
    end
  endtask

  task automatic test_sb;
    preload(3'd1, 32'h11223344);
    run_access(1'b0, 3'b000, 32'h5, 32'hFFFFFF55, 0);
    checks++;
    if ({first_addr, first_rw} !== {32'd1, 1'b1}) begin
      errors++; $display("FAIL sb_read_first: addr=%h rw=%b required 1/1", first_addr, first_rw);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL sb_latency: got %0d required 4", lat); end
    checks++;
    if (mem[1] !== 32'h11225544) begin
      errors++; $display("FAIL sb_word: got %h required 11225544", mem[1]);
    end
    checks++;
    if (oRDATA !== 32'h0000ABCD) begin
      errors++; $display("FAIL rdata_hold: got %h required 0000abcd", oRDATA);
    end
  endtask

  task automatic test_stall_sw;
    run_access(1'b0, 3'b010, 32'h4, 32'hCAFEF00D, 3);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL sw_stall_latency: got %0d required 5", lat); end
    checks++;
    if ({mem_seen, first_rw, wr_unstable, last_wr} !== {32'd4, 1'b0, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL sw_stall_hold: memcycles=%0d rw=%b unstable=%b data=%h required 4/0/0/cafef00d",
               mem_seen, first_rw, wr_unstable, last_wr);
    end
    checks++;
    if (mem[1] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL sw_word: got %h required cafef00d", mem[1]);
    end
  endtask

  task automatic test_faults;
    logic [31:0] fa [0:3];
    logic [2:0]  ff [0:3];
    logic        fl [0:3];
    logic [1:0]  fc [0:3];
    fa[0] = 32'h2;  ff[0] = 3'b010; fl[0] = 1'b1; fc[0] = 2'b01;
    fa[1] = 32'h20; ff[1] = 3'b010; fl[1] = 1'b1; fc[1] = 2'b10;
    fa[2] = 32'h0;  ff[2] = 3'b011; fl[2] = 1'b1; fc[2] = 2'b11;
    fa[3] = 32'h1;  ff[3] = 3'b110; fl[3] = 1'b0; fc[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_access(fl[i], ff[i], fa[i], 32'h0, 0);
      checks++;
      if ({exc_seen, oCAUSE, oDONE, lat, mem_seen} !== {1'b1, fc[i], 1'b0, 32'd1, 32'd0}) begin
        errors++;
        $display("FAIL fault_%0d: exc=%b cause=%b done=%b lat=%0d mem=%0d required 1/%b/0/1/0",
                 i, exc_seen, oCAUSE, oDONE, lat, mem_seen, fc[i]);
      end
    end
    @(posedge iCLK); #1;
    checks++;
    if ({oEXC, oCAUSE} !== 3'b011) begin
      errors++; $display("FAIL cause_hold: exc/cause=%b required 0/11", {oEXC, oCAUSE});
    end
  endtask

  task automatic test_back_to_back;
    iLOAD = 1'b0; iFUNCT3 = 3'b010; iADDR = 32'h0; iWDATA = 32'h12345678; iREQ = 1'b1;
    @(posedge iCLK); #1;
    iREQ = 1'b0;
    @(posedge iCLK); #1;
    checks++;
    if ({oDONE, oBUSY} !== 2'b10) begin
      errors++; $display("FAIL b2b_sw_done: done/busy=%b required 10", {oDONE, oBUSY});
    end
    iLOAD = 1'b1; iFUNCT3 = 3'b010; iADDR = 32'h0; iREQ = 1'b1;
    @(posedge iCLK); #1;
    iREQ = 1'b0;
    checks++;
    if ({oBUSY, oDONE, oMEM, oRW} !== 4'b1011) begin
      errors++; $display("FAIL b2b_accept: busy/done/mem/rw=%b required 1011", {oBUSY, oDONE, oMEM, oRW});
    end
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    checks++;
    if ({oDONE, oRDATA} !== {1'b1, 32'h12345678}) begin
      errors++; $display("FAIL b2b_lw: done=%b data=%h required 1/12345678", oDONE, oRDATA);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_sub_loads;
    test_sb;
    test_stall_sw;
    test_faults;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
